// File: rtl/mem1_stage.sv
// mem1_stage: first memory stage; registers execute results, checks alignment, issues the dcache request
module mem1_stage #(
  parameter logic [5:0] ECODE_ALE    = 6'h09,
  parameter logic [8:0] ESUBCODE_ALE = 9'h000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        next_rdy_in,
  output logic        rdy_in,
  input  logic        in_valid,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_ex_out,
  input  logic [31:0] in_rkd_data,
  input  logic        in_is_wr_rd,
  input  logic [4:0]  in_rd,
  input  logic        in_is_mem,
  input  logic        in_is_store,
  input  logic        in_is_signed,
  input  logic [1:0]  in_byte_type,
  input  logic        in_excp_valid,
  input  logic [14:0] in_excp_code,
  input  logic [31:0] in_badv,
  output logic        dc_req,
  output logic        dc_we,
  output logic [31:0] dc_addr,
  output logic [3:0]  dc_wstrb,
  output logic [31:0] dc_wdata,
  input  logic        dc_addr_ok,
  output logic        out_valid,
  output logic [31:0] out_pc,
  output logic [31:0] out_ex_out,
  output logic        out_is_wr_rd,
  output logic [4:0]  out_rd,
  output logic        out_is_load,
  output logic        out_is_signed,
  output logic [1:0]  out_byte_type,
  output logic [1:0]  out_addr_lo,
  output logic        out_excp_valid,
  output logic [14:0] out_excp_code,
  output logic [31:0] out_badv,
  output logic        fwd_valid,
  output logic [4:0]  fwd_idx,
  output logic        fwd_data_valid,
  output logic [31:0] fwd_data
);
  logic        valid_r, req_done;
  logic [31:0] pc_r, ex_out_r, rkd_r, badv_r;
  logic        is_wr_rd_r, is_mem_r, is_store_r, is_signed_r, excp_r;
  logic [4:0]  rd_r;
  logic [1:0]  byte_type_r;
  logic [14:0] excp_code_r;
  logic        m1_flush, m1_stall, misalign, is_half, is_word;

  // Control state: only valid and the issued-while-held flag need a defined reset value
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      valid_r  <= 1'b0;
      req_done <= 1'b0;
    end else begin
      if (rdy_in) valid_r <= in_valid;
      req_done <= (m1_flush | out_valid) ? 1'b0 : (req_done | (dc_req & dc_addr_ok & ~next_rdy_in));
    end

  // Payload register; contents are don't-care while valid_r is low
  always_ff @(posedge clk)
    if (rdy_in) begin
      pc_r        <= in_pc;
      ex_out_r    <= in_ex_out;
      rkd_r       <= in_rkd_data;
      is_wr_rd_r  <= in_is_wr_rd;
      rd_r        <= in_rd;
      is_mem_r    <= in_is_mem;
      is_store_r  <= in_is_store;
      is_signed_r <= in_is_signed;
      byte_type_r <= in_byte_type;
      excp_r      <= in_excp_valid;
      excp_code_r <= in_excp_code;
      badv_r      <= in_badv;
    end

  // Handshake, alignment, request, strobe/data and forwarding decode
  always_comb begin
    is_half        = byte_type_r == 2'd1;
    is_word        = byte_type_r[1];
    misalign       = is_mem_r & ((is_half & ex_out_r[0]) | (is_word & |ex_out_r[1:0]));
    m1_flush       = flush | ~valid_r;
    dc_req         = ~m1_flush & is_mem_r & ~excp_r & ~misalign & ~req_done;
    m1_stall       = (dc_req & ~dc_addr_ok) | ~next_rdy_in;
    rdy_in         = m1_flush | ~m1_stall;
    out_valid      = ~m1_flush & ~m1_stall;
    dc_we          = is_store_r;
    dc_addr        = ex_out_r;
    dc_wstrb       = ~is_store_r ? 4'b0000 :
                     is_word     ? 4'b1111 :
                     is_half     ? 4'b0011 << {ex_out_r[1], 1'b0} :
                                   4'b0001 << ex_out_r[1:0];
    dc_wdata       = is_word ? rkd_r : is_half ? {2{rkd_r[15:0]}} : {4{rkd_r[7:0]}};
    out_pc         = pc_r;
    out_ex_out     = ex_out_r;
    out_is_wr_rd   = is_wr_rd_r;
    out_rd         = rd_r;
    out_is_load    = is_mem_r & ~is_store_r;
    out_is_signed  = is_signed_r;
    out_byte_type  = byte_type_r;
    out_addr_lo    = ex_out_r[1:0];
    out_excp_valid = out_valid & (excp_r | misalign);
    out_excp_code  = excp_r ? excp_code_r : {ESUBCODE_ALE, ECODE_ALE};
    out_badv       = excp_r ? badv_r : ex_out_r;
    fwd_valid      = is_wr_rd_r & ~m1_flush;
    fwd_idx        = rd_r;
    fwd_data       = ex_out_r;
    fwd_data_valid = ~(is_mem_r & ~is_store_r);
  end
endmodule

// File: tb/tb_mem1_stage.sv
// tb_mem1_stage: directed plus random stimulus against a transaction-level model of mem1_stage
module tb_mem1_stage;
  logic        clk = 0, rst = 1, flush = 0, next_rdy_in = 1, rdy_in;
  logic        in_valid = 0;
  logic [31:0] in_pc = 0, in_ex_out = 0, in_rkd_data = 0, in_badv = 0;
  logic        in_is_wr_rd = 0, in_is_mem = 0, in_is_store = 0, in_is_signed = 0, in_excp_valid = 0;
  logic [4:0]  in_rd = 0;
  logic [1:0]  in_byte_type = 0;
  logic [14:0] in_excp_code = 0;
  logic        dc_req, dc_we, dc_addr_ok = 0;
  logic [31:0] dc_addr, dc_wdata;
  logic [3:0]  dc_wstrb;
  logic        out_valid, out_is_wr_rd, out_is_load, out_is_signed, out_excp_valid;
  logic [31:0] out_pc, out_ex_out, out_badv;
  logic [4:0]  out_rd;
  logic [1:0]  out_byte_type, out_addr_lo;
  logic [14:0] out_excp_code;
  logic        fwd_valid, fwd_data_valid;
  logic [4:0]  fwd_idx;
  logic [31:0] fwd_data;

  mem1_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .next_rdy_in(next_rdy_in), .rdy_in(rdy_in),
    .in_valid(in_valid), .in_pc(in_pc), .in_ex_out(in_ex_out), .in_rkd_data(in_rkd_data),
    .in_is_wr_rd(in_is_wr_rd), .in_rd(in_rd), .in_is_mem(in_is_mem), .in_is_store(in_is_store),
    .in_is_signed(in_is_signed), .in_byte_type(in_byte_type), .in_excp_valid(in_excp_valid),
    .in_excp_code(in_excp_code), .in_badv(in_badv),
    .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr), .dc_wstrb(dc_wstrb), .dc_wdata(dc_wdata),
    .dc_addr_ok(dc_addr_ok),
    .out_valid(out_valid), .out_pc(out_pc), .out_ex_out(out_ex_out), .out_is_wr_rd(out_is_wr_rd),
    .out_rd(out_rd), .out_is_load(out_is_load), .out_is_signed(out_is_signed),
    .out_byte_type(out_byte_type), .out_addr_lo(out_addr_lo), .out_excp_valid(out_excp_valid),
    .out_excp_code(out_excp_code), .out_badv(out_badv),
    .fwd_valid(fwd_valid), .fwd_idx(fwd_idx), .fwd_data_valid(fwd_data_valid), .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc, ex, rkd, badv;
    logic        wr, mem, st, sg, ev;
    logic [4:0]  rd;
    logic [1:0]  bt;
    logic [14:0] ec;
  } ins_t;

  ins_t m;
  bit   m_valid, m_done;
  int   checks, errors;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, o, e);
    end
  endtask

  task automatic setin(input logic [31:0] addr, input logic [31:0] rkd, input bit mem, input bit st,
                       input logic [1:0] bt, input bit ev);
    in_valid = 1; in_pc = $urandom; in_ex_out = addr; in_rkd_data = rkd;
    in_is_mem = mem; in_is_store = st; in_byte_type = bt; in_excp_valid = ev;
    in_excp_code = 15'($urandom); in_badv = $urandom; in_is_wr_rd = !(mem && st);
    in_rd = 5'($urandom); in_is_signed = 1'($urandom);
  endtask

  task automatic model_reset;
    m_valid = 0;
    m_done  = 0;
  endtask

  // Compares all outputs against the model at negedge+1, then advances the model one cycle
  task automatic tick;
    int sz;
    bit kill, mis, needs, req, ov, exc;
    logic [31:0] a, strb;
    #1;
    a     = m.ex;
    sz    = m.bt == 0 ? 1 : m.bt == 1 ? 2 : 4;
    kill  = flush || !m_valid;
    mis   = m.mem && (a % sz != 0);
    exc   = m.ev || mis;
    needs = m.mem && !exc;
    req   = !kill && needs && !m_done;
    ov    = !kill && next_rdy_in && (!needs || m_done || dc_addr_ok);
    strb  = m.st ? ((32'd1 << sz) - 1) << (a % 4) : 0;
    chk("rdy_in", rdy_in, kill || ov);
    chk("out_valid", out_valid, ov);
    chk("dc_req", dc_req, req);
    if (req) begin
      chk("dc_we", dc_we, m.st);
      chk("dc_addr", dc_addr, a);
      chk("dc_wstrb", dc_wstrb, strb);
      if (m.st) chk("dc_wdata", dc_wdata, sz == 1 ? m.rkd[7:0] * 32'h01010101 :
                                          sz == 2 ? m.rkd[15:0] * 32'h00010001 : m.rkd);
    end
    chk("out_excp_valid", out_excp_valid, ov && exc);
    if (ov) begin
      chk("out_pc", out_pc, m.pc);
      chk("out_ex_out", out_ex_out, a);
      chk("out_is_wr_rd", out_is_wr_rd, m.wr);
      chk("out_rd", out_rd, m.rd);
      chk("out_is_load", out_is_load, m.mem && !m.st);
      chk("out_is_signed", out_is_signed, m.sg);
      chk("out_byte_type", out_byte_type, m.bt);
      chk("out_addr_lo", out_addr_lo, a % 4);
      if (exc) begin
        chk("out_excp_code", out_excp_code, m.ev ? m.ec : 15'h0009);
        chk("out_badv", out_badv, m.ev ? m.badv : a);
      end
    end
    chk("fwd_valid", fwd_valid, m.wr && !kill);
    if (m.wr && !kill) begin
      chk("fwd_idx", fwd_idx, m.rd);
      chk("fwd_data", fwd_data, a);
      chk("fwd_data_valid", fwd_data_valid, !(m.mem && !m.st));
    end
    if (kill || ov) begin
      m_valid = in_valid; m_done = 0;
      m.pc = in_pc; m.ex = in_ex_out; m.rkd = in_rkd_data; m.badv = in_badv;
      m.wr = in_is_wr_rd; m.mem = in_is_mem; m.st = in_is_store; m.sg = in_is_signed;
      m.ev = in_excp_valid; m.rd = in_rd; m.bt = in_byte_type; m.ec = in_excp_code;
    end else if (req && dc_addr_ok) m_done = 1;
    @(negedge clk);
  endtask

  initial begin
    checks = 0; errors = 0;
    model_reset();
    m = '{default: '0};
    repeat (2) @(negedge clk);
    #1;
    chk("reset dc_req", dc_req, 0);
    chk("reset out_valid", out_valid, 0);
    chk("reset fwd_valid", fwd_valid, 0);
    chk("reset rdy_in", rdy_in, 1);
    @(negedge clk);
    rst = 0;
    // word load, granted immediately
    dc_addr_ok = 1; next_rdy_in = 1;
    setin(32'h1000, $urandom, 1, 0, 2, 0); tick();
    in_valid = 0; tick();
    // byte store to the top lane
    setin(32'h2003, 32'h000000AB, 1, 1, 0, 0); tick();
    in_valid = 0; tick();
    // misaligned half load raises ALE
    setin(32'h3001, $urandom, 1, 0, 1, 0); tick();
    in_valid = 0;
    #1;
    chk("ale code", out_excp_code, 15'h0009);
    chk("ale badv", out_badv, 32'h3001);
    tick();
    // word store waiting three cycles for the dcache
    dc_addr_ok = 0;
    setin(32'h4000, $urandom, 1, 1, 2, 0); tick();
    in_valid = 0;
    repeat (3) tick();
    dc_addr_ok = 1; tick();
    // accepted while memory2 is not ready, then held without re-issue
    next_rdy_in = 0;
    setin(32'h5000, $urandom, 1, 0, 2, 0); tick();
    in_valid = 0; tick();
    dc_addr_ok = 0; tick();
    dc_addr_ok = 1; tick();
    next_rdy_in = 1; tick();
    // flush while stalled on the dcache
    dc_addr_ok = 0;
    setin(32'h6000, $urandom, 1, 1, 2, 0); tick();
    in_valid = 0; tick();
    flush = 1; tick();
    flush = 0; tick();
    // reset while stalled
    setin(32'h7000, $urandom, 1, 0, 2, 0); tick();
    in_valid = 0; tick();
    rst = 1;
    #1;
    chk("rst dc_req", dc_req, 0);
    chk("rst out_valid", out_valid, 0);
    chk("rst fwd_valid", fwd_valid, 0);
    model_reset();
    @(negedge clk);
    rst = 0;
    // random traffic
    repeat (600) begin
      setin($urandom, $urandom, $urandom_range(0, 3) != 0, 1'($urandom), 2'($urandom),
            $urandom_range(0, 9) == 0);
      in_valid    = $urandom_range(0, 4) != 0;
      flush       = $urandom_range(0, 9) == 0;
      next_rdy_in = $urandom_range(0, 4) != 0;
      dc_addr_ok  = $urandom_range(0, 4) < 3;
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
